// File: rtl/freq_table_ctrl.sv
// Byte-frequency table sequencer: clears the count memory, increments one entry per input
// byte through a single memory port, then serves random-access readout of the counts.
module freq_table_ctrl #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              stream_done,
    input  logic              rd_req,
    input  logic [7:0]        rd_idx,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r,
    output logic              mem_w,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CLEAR    = 4'd1;
    localparam logic [3:0] ST_ACCEPT   = 4'd2;
    localparam logic [3:0] ST_READ     = 4'd3;
    localparam logic [3:0] ST_WAIT     = 4'd4;
    localparam logic [3:0] ST_WRITE    = 4'd5;
    localparam logic [3:0] ST_DONE     = 4'd6;
    localparam logic [3:0] ST_RD_ISSUE = 4'd7;
    localparam logic [3:0] ST_RD_CAP   = 4'd8;

    localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};

    logic [3:0]        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic              sat_q, sat_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_ack_q, rd_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Index is zero-extended before the offset; the sum wraps at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] entry_addr(input logic [7:0] i);
        return BASE_ADDR + ADDR_W'(i);
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sat_d    = sat_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        rd_ack_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    idx_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (byte_valid) begin
                    idx_d   = byte_data;
                    state_d = ST_READ;
                end else if (stream_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Incremented value is prepared here so the write strobe can be a plain flop.
                sat_d   = (mem_rdata == CNT_MAX);
                wdata_d = (mem_rdata == CNT_MAX) ? mem_rdata : mem_rdata + DATA_W'(1);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (sat_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_ACCEPT;
            end
            ST_DONE: begin
                if (rd_req) begin
                    idx_d   = rd_idx;
                    state_d = ST_RD_ISSUE;
                end else if (start) begin
                    state_d = ST_CLEAR;
                    idx_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rd_cnt_d = mem_rdata;
                rd_ack_d = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        mem_r_d = (state_d == ST_READ) || (state_d == ST_RD_ISSUE);
        mem_w_d = (state_d == ST_CLEAR) || (state_d == ST_WRITE);
        if (state_d == ST_CLEAR) begin
            wdata_d = '0;
        end
        if (mem_r_d || mem_w_d) begin
            addr_d = entry_addr(idx_d);
        end
        ready_d = (state_d == ST_ACCEPT);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 8'd0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            rd_ack_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_r_q  <= 1'b0;
            mem_w_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            rd_ack_q <= rd_ack_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_r_q  <= mem_r_d;
            mem_w_q  <= mem_w_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign byte_ready = ready_q;
    assign rd_ack     = rd_ack_q;
    assign rd_cnt     = rd_cnt_q;
    assign mem_addr   = addr_q;
    assign mem_r      = mem_r_q;
    assign mem_w      = mem_w_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/freq_table_ctrl.md
# freq_table_ctrl

Sequencing controller for the byte-frequency count table used by the compression front end. It owns the single-port count memory. It clears the table, then performs a read-modify-write increment for every incoming byte of the stream. After the stream ends, it serves random-access readout requests from the downstream tree builder. All memory traffic is serialized through one port, so the memory is never read and written in the same cycle.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 8, count width; counts saturate at 2^DATA_W-1
- BASE_ADDR, 10'h000, address of table entry 0; entry i lives at BASE_ADDR+i

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin new histogram (clear + count)
- byte_valid  in  1  input byte present
- byte_data  in  8  input byte (table index)
- byte_ready  out  1  controller accepts byte this cycle
- stream_done  in  1  level: no more bytes; held by source until done=1
- rd_req  in  1  readout request (honored only in DONE)
- rd_idx  in  8  entry to read
- rd_ack  out  1  one-cycle pulse: rd_cnt valid
- rd_cnt  out  DATA_W  count of last requested entry; holds until next ack
- mem_addr  out  ADDR_W  memory address
- mem_r  out  1  memory read strobe; mem_rdata valid the following cycle
- mem_w  out  1  memory write strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- err  out  1  sticky saturation flag

## Operation
- States: IDLE, CLEAR, ACCEPT, READ, WAIT, WRITE, DONE, RD_ISSUE, RD_CAP.
- IDLE: start=1 -> CLEAR; clear err; index counter = 0.
- CLEAR: mem_w=1, mem_wdata=0, mem_addr=BASE_ADDR+idx. idx increments every cycle. After idx=255 is written -> ACCEPT. The sweep takes exactly 256 cycles.
- ACCEPT: byte_ready=1.
  - byte_valid=1: latch byte_data -> READ.
  - Otherwise, stream_done=1 -> DONE.
  - If byte_valid and stream_done are high together, the byte is accepted and stream_done is re-sampled on the next ACCEPT.
- READ: mem_r=1, mem_addr=BASE_ADDR+byte.
- WAIT: register mem_rdata.
- WRITE: mem_w=1, same address.
  - mem_wdata = count+1, or count unchanged when count=2^DATA_W-1. In the saturated case err is set.
  - Next state -> ACCEPT.
- DONE: done=1.
  - rd_req=1: latch rd_idx -> RD_ISSUE.
  - Otherwise, start=1 -> CLEAR (new histogram; err cleared).
  - If rd_req and start are high together, rd_req wins.
- RD_ISSUE: mem_r=1, mem_addr=BASE_ADDR+idx.
- RD_CAP: rd_cnt <= mem_rdata -> DONE, with rd_ack=1 in that first DONE cycle.
- start is ignored in every state except IDLE and DONE. byte_valid is ignored outside ACCEPT. rd_req is ignored outside DONE.
- Index is zero-extended to ADDR_W before adding BASE_ADDR. The address wraps modulo 2^ADDR_W.
- mem_r and mem_w are never high in the same cycle. Strobes are registered outputs of the state.

## Timing
- Reset values: state IDLE. All outputs 0, including mem_addr=0, mem_wdata=0, rd_cnt=0, err=0.
- rst mid-operation: next cycle the controller is in IDLE and all strobes are low. Memory contents are left as-is (not cleared); the next start re-clears.
- Per byte: 4 cycles (ACCEPT, READ, WAIT, WRITE). byte_ready is high at most 1 cycle in 4 while counting.
- Start to first byte_ready: start sampled at T, CLEAR during T+1..T+256, byte_ready=1 at T+257.
- stream_done sampled in ACCEPT at T -> done=1 at T+1.
- Readout: rd_req sampled in DONE at T. mem_r at T+1, capture at T+2, rd_ack=1 and rd_cnt valid at T+3. A new rd_req is accepted in the rd_ack cycle.
- err asserts the cycle after the saturating WRITE and stays high until start or rst.

## Test plan
- rst, start, then count mem_w during the sweep -> exactly 256 writes of 0 to addresses BASE_ADDR..BASE_ADDR+255, byte_ready rises 257 cycles after start.
- Bytes 0x00,0x00,0x01,0x01, then stream_done; read idx 0, 1, 5 -> rd_cnt 2, 2, 0; each rd_ack 3 cycles after rd_req; err=0.
- 256 bytes of 0xAA -> read idx 0xAA gives 255, err=1; a further 0xAA byte writes 255 again; err stays 1 until next start.
- byte_valid held high continuously -> byte_ready pulses every 4th cycle; memory never sees mem_r and mem_w together.
- rst asserted during WRITE -> next cycle mem_w=0, busy=0, done=0; start pulse while busy (no rst) -> ignored, counting continues.
- BASE_ADDR=10'h3F0, byte 0x20 -> mem_addr=10'h010 (wrap); stream_done with byte_valid same cycle -> byte counted, then done.
